// File: rtl/gelato_warp_inst_buffer.sv
// Per-warp instruction buffer: one circular FIFO per warp between decode and issue,
// with targeted pop, per-warp flush, occupancy/almost-full status and a sticky underflow flag.
module gelato_warp_inst_buffer #(
  parameter int NUM_WARPS    = 4,
  parameter int DEPTH        = 4,
  parameter int INST_WIDTH   = 64,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int WID_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy,
  input  logic                            push_valid,
  input  logic [WID_W-1:0]                push_warp,
  input  logic [INST_WIDTH-1:0]           push_inst,
  output logic                            push_ready,
  input  logic                            pop_en,
  input  logic [WID_W-1:0]                pop_warp,
  input  logic [NUM_WARPS-1:0]            flush,
  output logic [NUM_WARPS-1:0]            head_valid,
  output logic [NUM_WARPS*INST_WIDTH-1:0] head_inst,
  output logic [NUM_WARPS*CNT_W-1:0]      count,
  output logic [NUM_WARPS-1:0]            afull,
  output logic                            underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INST_WIDTH-1:0] mem  [NUM_WARPS][DEPTH];
  logic [PTR_W-1:0]      wptr [NUM_WARPS];
  logic [PTR_W-1:0]      rptr [NUM_WARPS];
  logic [CNT_W-1:0]      cnt  [NUM_WARPS];

  logic [NUM_WARPS-1:0]  push_fire;
  logic [NUM_WARPS-1:0]  pop_fire;
  logic                  underflow_set;

  // Push handshake: a transfer happens on a rising edge where rdy, push_valid and
  // push_ready are all high and the target warp is not being flushed. push_ready
  // depends only on registered occupancy and push_warp, never on a same-cycle pop.
  always_comb begin
    push_ready    = 1'b0;
    underflow_set = 1'b0;
    push_fire     = '0;
    pop_fire      = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (push_warp == WID_W'(w)) begin
        push_ready   = (cnt[w] != CNT_W'(DEPTH));
        push_fire[w] = rdy & push_valid & push_ready & ~flush[w];
      end
      if (pop_warp == WID_W'(w)) begin
        pop_fire[w]   = rdy & pop_en & (cnt[w] != '0) & ~flush[w];
        // A flushed warp swallows the pop, so an empty-pop there is not an error
        underflow_set = rdy & pop_en & (cnt[w] == '0) & ~flush[w];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        wptr[w] <= '0;
        rptr[w] <= '0;
        cnt[w]  <= '0;
      end
      underflow_err <= 1'b0;
    end else if (rdy) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (flush[w]) begin
          wptr[w] <= '0;
          rptr[w] <= '0;
          cnt[w]  <= '0;
        end else begin
          if (push_fire[w]) wptr[w] <= wptr[w] + PTR_W'(1);
          if (pop_fire[w])  rptr[w] <= rptr[w] + PTR_W'(1);
          cnt[w] <= cnt[w] + CNT_W'(push_fire[w]) - CNT_W'(pop_fire[w]);
        end
      end
      if (underflow_set) underflow_err <= 1'b1;
    end
  end

  // Payload storage is deliberately not reset; only pointers and counts are.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (push_fire[w]) mem[w][wptr[w]] <= push_inst;
    end
  end

  always_comb begin
    head_valid = '0;
    head_inst  = '0;
    count      = '0;
    afull      = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      head_valid[w]                      = (cnt[w] != '0);
      head_inst[w*INST_WIDTH +: INST_WIDTH] = mem[w][rptr[w]];
      count[w*CNT_W +: CNT_W]            = cnt[w];
      afull[w]                           = (cnt[w] >= CNT_W'(AFULL_THRESH));
    end
  end

endmodule

// File: tb/tb_gelato_warp_inst_buffer.sv
// Self-checking bench for gelato_warp_inst_buffer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-per-warp reference model.
module tb_gelato_warp_inst_buffer;

  localparam int NW = 4;
  localparam int D  = 4;
  localparam int IW = 64;
  localparam int CW = 3;

  logic           clk;
  logic           rst;
  logic           rdy;
  logic           push_valid;
  logic [1:0]     push_warp;
  logic [IW-1:0]  push_inst;
  logic           push_ready;
  logic           pop_en;
  logic [1:0]     pop_warp;
  logic [NW-1:0]  flush;
  logic [NW-1:0]  head_valid;
  logic [NW*IW-1:0] head_inst;
  logic [NW*CW-1:0] count;
  logic [NW-1:0]  afull;
  logic           underflow_err;

  gelato_warp_inst_buffer #(
    .NUM_WARPS(NW), .DEPTH(D), .INST_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .push_valid(push_valid), .push_warp(push_warp), .push_inst(push_inst),
    .push_ready(push_ready), .pop_en(pop_en), .pop_warp(pop_warp),
    .flush(flush), .head_valid(head_valid), .head_inst(head_inst),
    .count(count), .afull(afull), .underflow_err(underflow_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: one queue of instructions per warp plus the sticky error bit
  logic [IW-1:0] mq [NW][$];
  bit            m_uf;

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++) mq[w].delete();
    m_uf = 1'b0;
  endtask

  task automatic drive(input bit r, input bit pv, input logic [1:0] pw, input logic [IW-1:0] pi,
                       input bit pe, input logic [1:0] ppw, input logic [NW-1:0] fl);
    rdy = r; push_valid = pv; push_warp = pw; push_inst = pi;
    pop_en = pe; pop_warp = ppw; flush = fl;
    #1;
  endtask

  // one clock edge; the model applies the same cycle's request from the rules
  task automatic tick();
    bit do_push, do_pop;
    @(posedge clk);
    if (rdy) begin
      do_push = push_valid && (mq[push_warp].size() < D) && !flush[push_warp];
      do_pop  = pop_en && (mq[pop_warp].size() > 0) && !flush[pop_warp];
      if (pop_en && (mq[pop_warp].size() == 0) && !flush[pop_warp]) m_uf = 1'b1;
      if (do_pop) void'(mq[pop_warp].pop_front());
      if (do_push) mq[push_warp].push_back(push_inst);
      for (int w = 0; w < NW; w++) if (flush[w]) mq[w].delete();
    end
    #1;
  endtask

  task automatic check_push_ready();
    chk("push_ready", 64'(push_ready), 64'(mq[push_warp].size() != D));
  endtask

  task automatic check_model(input string tag);
    logic [NW-1:0]    e_hv, e_af;
    logic [NW*CW-1:0] e_cnt;
    e_hv = '0; e_af = '0; e_cnt = '0;
    for (int w = 0; w < NW; w++) begin
      e_hv[w] = mq[w].size() > 0;
      e_af[w] = mq[w].size() >= D - 1;
      e_cnt[w*CW +: CW] = CW'(mq[w].size());
    end
    chk({tag, "_head_valid"}, 64'(head_valid), 64'(e_hv));
    chk({tag, "_count"}, 64'(count), 64'(e_cnt));
    chk({tag, "_afull"}, 64'(afull), 64'(e_af));
    chk({tag, "_underflow"}, 64'(underflow_err), 64'(m_uf));
    for (int w = 0; w < NW; w++)
      if (mq[w].size() > 0) chk({tag, "_head_inst"}, head_inst[w*IW +: IW], mq[w][0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, '0, 1'b0, 2'd0, '0);
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_head_valid", 64'(head_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_afull", 64'(afull), 64'(0));
    chk("rst_underflow", 64'(underflow_err), 64'(0));
    chk("rst_push_ready", 64'(push_ready), 64'(1));
    rst = 1'b0;
  endtask

  // directed vector table
  typedef struct {
    logic r, pv; logic [1:0] pw; logic [IW-1:0] pi; logic pe; logic [1:0] ppw; logic [NW-1:0] fl;
    logic exp_pr; logic [NW-1:0] exp_hv; logic [NW*CW-1:0] exp_cnt; logic [NW-1:0] exp_af;
    logic exp_uf; logic [1:0] chk_w; logic [IW-1:0] exp_head;
  } vec_t;

  vec_t tbl [15];

  initial begin
    //          r  pv pw  pi       pe ppw fl        pr hv       cnt      af       uf w  head
    tbl[0]  = '{1, 1, 2, 64'hA5, 0, 0, 4'b0000, 1, 4'b0100, 12'h040, 4'b0000, 0, 2, 64'hA5};
    tbl[1]  = '{1, 1, 1, 64'h10, 0, 0, 4'b0000, 1, 4'b0110, 12'h048, 4'b0000, 0, 1, 64'h10};
    tbl[2]  = '{1, 1, 1, 64'h11, 0, 0, 4'b0000, 1, 4'b0110, 12'h050, 4'b0000, 0, 1, 64'h10};
    tbl[3]  = '{1, 1, 1, 64'h12, 0, 0, 4'b0000, 1, 4'b0110, 12'h058, 4'b0010, 0, 1, 64'h10};
    tbl[4]  = '{1, 1, 1, 64'h13, 0, 0, 4'b0000, 1, 4'b0110, 12'h060, 4'b0010, 0, 1, 64'h10};
    tbl[5]  = '{1, 1, 1, 64'h14, 0, 0, 4'b0000, 0, 4'b0110, 12'h060, 4'b0010, 0, 1, 64'h10};
    tbl[6]  = '{1, 0, 0, 64'h0,  1, 1, 4'b0000, 1, 4'b0110, 12'h058, 4'b0010, 0, 1, 64'h11};
    tbl[7]  = '{1, 0, 0, 64'h0,  1, 1, 4'b0000, 1, 4'b0110, 12'h050, 4'b0000, 0, 1, 64'h12};
    tbl[8]  = '{1, 0, 0, 64'h0,  1, 1, 4'b0000, 1, 4'b0110, 12'h048, 4'b0000, 0, 1, 64'h13};
    tbl[9]  = '{1, 0, 0, 64'h0,  1, 1, 4'b0000, 1, 4'b0100, 12'h040, 4'b0000, 0, 2, 64'hA5};
    tbl[10] = '{1, 0, 0, 64'h0,  1, 1, 4'b0000, 1, 4'b0100, 12'h040, 4'b0000, 1, 2, 64'hA5};
    tbl[11] = '{0, 1, 0, 64'h77, 1, 2, 4'b1111, 1, 4'b0100, 12'h040, 4'b0000, 1, 2, 64'hA5};
    tbl[12] = '{0, 1, 0, 64'h77, 1, 2, 4'b1111, 1, 4'b0100, 12'h040, 4'b0000, 1, 2, 64'hA5};
    tbl[13] = '{0, 1, 0, 64'h77, 1, 2, 4'b1111, 1, 4'b0100, 12'h040, 4'b0000, 1, 2, 64'hA5};
    tbl[14] = '{1, 0, 0, 64'h0,  1, 2, 4'b0100, 1, 4'b0000, 12'h000, 4'b0000, 1, 0, 64'h0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, '0, 1'b0, 2'd0, '0);

    // table-driven directed vectors
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r, tbl[i].pv, tbl[i].pw, tbl[i].pi, tbl[i].pe, tbl[i].ppw, tbl[i].fl);
      chk($sformatf("vec%0d_push_ready", i), 64'(push_ready), 64'(tbl[i].exp_pr));
      tick();
      chk($sformatf("vec%0d_head_valid", i), 64'(head_valid), 64'(tbl[i].exp_hv));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_afull", i), 64'(afull), 64'(tbl[i].exp_af));
      chk($sformatf("vec%0d_underflow", i), 64'(underflow_err), 64'(tbl[i].exp_uf));
      if (tbl[i].exp_hv[tbl[i].chk_w])
        chk($sformatf("vec%0d_head_inst", i), head_inst[tbl[i].chk_w*IW +: IW], tbl[i].exp_head);
    end

    // simultaneous push+pop at count 1, across pointer wrap
    do_reset();
    drive(1'b1, 1'b1, 2'd0, 64'h21, 1'b0, 2'd0, '0);
    tick();
    for (int i = 0; i < 2*D; i++) begin
      drive(1'b1, 1'b1, 2'd0, 64'h22 + 64'(i), 1'b1, 2'd0, '0);
      check_push_ready();
      tick();
      chk("wrap_count0", 64'(count[0 +: CW]), 64'(1));
      chk("wrap_head0", head_inst[0 +: IW], 64'h22 + 64'(i));
    end
    check_model("wrap");

    // push+pop at count DEPTH-1 keeps the count
    for (int i = 0; i < D-2; i++) begin
      drive(1'b1, 1'b1, 2'd0, 64'h40 + 64'(i), 1'b0, 2'd0, '0);
      tick();
    end
    drive(1'b1, 1'b1, 2'd0, 64'h4F, 1'b1, 2'd0, '0);
    tick();
    chk("dm1_count0", 64'(count[0 +: CW]), 64'(D-1));
    check_model("dm1");

    // flush of warp 3 beats a pop on 3 while warp 0 takes a push
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd3, 64'h30 + 64'(i), 1'b0, 2'd0, '0);
      tick();
    end
    drive(1'b1, 1'b1, 2'd0, 64'h55, 1'b1, 2'd3, 4'b1000);
    tick();
    chk("flush_count", 64'(count), 64'h001);
    chk("flush_head_valid", 64'(head_valid), 64'b0001);
    chk("flush_underflow", 64'(underflow_err), 64'(0));
    chk("flush_head0", head_inst[0 +: IW], 64'h55);
    drive(1'b1, 1'b0, 2'd0, '0, 1'b1, 2'd3, 4'b1000);
    tick();
    chk("flush_emptypop_underflow", 64'(underflow_err), 64'(0));
    check_model("flush");

    // asynchronous reset mid-stream clears without a clock edge
    drive(1'b1, 1'b1, 2'd2, 64'h66, 1'b0, 2'd0, '0);
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_head_valid", 64'(head_valid), 64'(0));
    chk("async_rst_count", 64'(count), 64'(0));
    model_clear();
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [NW-1:0] fl;
      fl = '0;
      for (int w = 0; w < NW; w++) fl[w] = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 2'($urandom_range(0, NW-1)),
            {$urandom, $urandom}, $urandom_range(0, 9) < 4, 2'($urandom_range(0, NW-1)), fl);
      check_push_ready();
      tick();
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
